// File: rtl/otter_uart_tx.sv
// Memory-mapped UART transmitter for the OTTER I/O bus: TXDATA pushes into a small FIFO,
// STATUS/CTRL reports FIFO/FSM state and holds the interrupt enable and sticky overflow.
module otter_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0200,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] iobus_addr,
  input  logic [31:0] iobus_out,
  input  logic        iobus_wr,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        intr
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              CW        = AW + 1;
  localparam logic [31:0]     CTRL_ADDR = BASE_ADDR + 32'd4;
  localparam logic [CW-1:0]   DEPTH     = CW'(FIFO_DEPTH);
  localparam logic [15:0]     BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          irq_en;
  logic          overflow;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic txdata_wr;
  logic ctrl_wr;
  logic empty;
  logic full;
  logic busy;
  logic baud_done;
  logic push;
  logic pop;
  logic [4:0] count5;
  logic unused_bits;

  assign txdata_wr   = iobus_wr && (iobus_addr == BASE_ADDR);
  assign ctrl_wr     = iobus_wr && (iobus_addr == CTRL_ADDR);
  assign empty       = (count == '0);
  assign full        = (count == DEPTH);
  assign busy        = (state != IDLE);
  assign baud_done   = (baud_cnt == BAUD_LAST);
  assign count5      = 5'(count);
  assign unused_bits = ^iobus_out[31:8];

  // Fullness is judged on the count at the start of the cycle, so a same-cycle pop
  // never makes room for a push into a full FIFO.
  assign push = txdata_wr && !full;
  assign pop  = !empty && ((state == IDLE) || ((state == STOP) && baud_done));

  always_comb begin
    rd_data = 32'b0;
    if (iobus_addr == CTRL_ADDR)
      rd_data = {22'b0, overflow, irq_en, busy, full, empty, count5};
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= iobus_out[7:0];
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (txdata_wr && full) overflow <= 1'b1;
      if (ctrl_wr) begin
        irq_en <= iobus_out[0];
        if (iobus_out[1]) overflow <= 1'b0;
      end
    end
  end

  // tx is driven from the current state, so the line trails the state by one cycle.
  always_ff @(posedge clk) begin
    if (RST) begin
      state    <= IDLE;
      tx       <= 1'b1;
      intr     <= 1'b0;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
    end else begin
      intr <= 1'b0;
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= 16'd0;
          if (!empty) begin
            shift <= mem[rd_ptr];
            state <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (baud_done) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          tx <= shift[0];
          if (baud_done) begin
            baud_cnt <= 16'd0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baud_done) begin
            baud_cnt <= 16'd0;
            if (!empty) begin
              shift <= mem[rd_ptr];
              state <= START;
            end else begin
              state <= IDLE;
              intr  <= irq_en;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_uart_tx.sv
// Bench for otter_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4: register/decode vector table,
// then frame sequences checked cycle by cycle against an expected {tx,intr} queue.
module tb_otter_uart_tx;

  localparam logic [31:0] BASE = 32'h1100_0200;
  localparam logic [31:0] CTRL = BASE + 32'd4;

  logic        clk;
  logic        RST;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] rd_data;
  logic        tx;
  logic        intr;

  int checks   = 0;
  int failures = 0;
  int mon_n    = 0;
  logic mon_active;
  logic [1:0] mon_e;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[11];

  otter_uart_tx #(
    .BASE_ADDR(BASE),
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .RST(RST),
    .iobus_addr(iobus_addr),
    .iobus_out(iobus_out),
    .iobus_wr(iobus_wr),
    .rd_data(rd_data),
    .tx(tx),
    .intr(intr)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    iobus_addr = a;
    iobus_out  = d;
    iobus_wr   = 1'b1;
    step();
    iobus_wr   = 1'b0;
    iobus_addr = CTRL;
    iobus_out  = 32'h0;
    #1;
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(2'b10);
  endtask

  // One 10-bit frame at 4 clocks per bit; intr may fire only on its last cycle.
  task automatic push_frame(input logic [7:0] b, input logic last_irq);
    for (int i = 0; i < 4; i++) exp_q.push_back(2'b00);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < 4; i++) exp_q.push_back({b[k], 1'b0});
    for (int i = 0; i < 3; i++) exp_q.push_back(2'b10);
    exp_q.push_back({1'b1, last_irq});
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) step();
  endtask

  // scoreboard monitor: samples between the driver's activity and the next edge
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (mon_active) begin
        if (exp_q.size() > 0) mon_e = exp_q.pop_front();
        else                  mon_e = 2'b10;
        check($sformatf("mon_tx@%0d", mon_n), {31'b0, tx}, {31'b0, mon_e[1]});
        check($sformatf("mon_intr@%0d", mon_n), {31'b0, intr}, {31'b0, mon_e[0]});
        mon_n++;
      end
    end
  end

  initial begin
    RST        = 1'b1;
    iobus_addr = CTRL;
    iobus_out  = 32'h0;
    iobus_wr   = 1'b0;
    mon_active = 1'b0;

    vecs[0]  = '{CTRL,                 32'h0,  1'b0, 32'h0000_0020};
    vecs[1]  = '{BASE,                 32'h0,  1'b0, 32'h0};
    vecs[2]  = '{BASE + 32'd8,         32'hFF, 1'b1, 32'h0};
    vecs[3]  = '{BASE - 32'd4,         32'hFF, 1'b1, 32'h0};
    vecs[4]  = '{32'h2100_0200,        32'hFF, 1'b1, 32'h0};
    vecs[5]  = '{CTRL,                 32'h0,  1'b0, 32'h0000_0020};
    vecs[6]  = '{32'h0,                32'h0,  1'b0, 32'h0};
    vecs[7]  = '{CTRL,                 32'h1,  1'b1, 32'h0000_0020};
    vecs[8]  = '{CTRL,                 32'h0,  1'b0, 32'h0000_0120};
    vecs[9]  = '{CTRL,                 32'h2,  1'b1, 32'h0000_0120};
    vecs[10] = '{CTRL,                 32'h0,  1'b0, 32'h0000_0020};

    step();
    step();
    RST = 1'b0;

    // reset state, decode isolation, CTRL register
    for (int i = 0; i < 11; i++) begin
      iobus_addr = vecs[i].addr;
      iobus_out  = vecs[i].wdata;
      iobus_wr   = vecs[i].wr;
      #1;
      check($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
      check($sformatf("vec%0d_tx", i), {31'b0, tx}, 32'd1);
      check($sformatf("vec%0d_intr", i), {31'b0, intr}, 32'd0);
      step();
    end
    iobus_wr   = 1'b0;
    iobus_addr = CTRL;
    iobus_out  = 32'h0;
    #1;
    mon_active = 1'b1;

    // single byte with interrupt enabled
    bus_write(CTRL, 32'h1);
    check("irq_en_set", rd_data, 32'h0000_0120);
    push_idle(3);
    push_frame(8'hA5, 1'b1);
    bus_write(BASE, 32'hA5);
    check("single_queued", rd_data, 32'h0000_0101);
    step();
    check("single_popped", rd_data, 32'h0000_01A0);
    wait_drain(100);
    check("single_done", rd_data, 32'h0000_0120);

    // back-to-back frames, one interrupt at the end
    push_idle(3);
    push_frame(8'h01, 1'b0);
    push_frame(8'h02, 1'b0);
    push_frame(8'h03, 1'b1);
    bus_write(BASE, 32'h01);
    bus_write(BASE, 32'h02);
    bus_write(BASE, 32'h03);
    check("b2b_count2", rd_data, 32'h0000_0182);
    wait_drain(200);

    // overflow: sixth byte dropped, then a push racing the first pop is dropped too
    push_idle(3);
    push_frame(8'h11, 1'b0);
    push_frame(8'h22, 1'b0);
    push_frame(8'h33, 1'b0);
    push_frame(8'h44, 1'b0);
    push_frame(8'h55, 1'b1);
    bus_write(BASE, 32'h11);
    bus_write(BASE, 32'h22);
    bus_write(BASE, 32'h33);
    bus_write(BASE, 32'h44);
    bus_write(BASE, 32'h55);
    bus_write(BASE, 32'h66);
    check("ovf_set", rd_data, 32'h0000_03C4);
    bus_write(CTRL, 32'h3);
    check("ovf_cleared", rd_data, 32'h0000_01C4);
    repeat (34) step();
    bus_write(BASE, 32'h77);
    check("ovf_pop_race", rd_data, 32'h0000_0383);
    bus_write(CTRL, 32'h3);
    check("ovf_cleared2", rd_data, 32'h0000_0183);
    wait_drain(300);
    check("ovf_done", rd_data, 32'h0000_0120);

    // reset during DATA bit 3
    mon_active = 1'b0;
    bus_write(BASE, 32'hC3);
    repeat (18) step();
    check("rst_pre_tx_bit3", {31'b0, tx}, 32'd0);
    check("rst_pre_status", rd_data, 32'h0000_01A0);
    RST = 1'b1;
    step();
    check("rst_tx_high", {31'b0, tx}, 32'd1);
    check("rst_intr_low", {31'b0, intr}, 32'd0);
    RST = 1'b0;
    #1;
    check("rst_status", rd_data, 32'h0000_0020);
    mon_active = 1'b1;
    repeat (50) step();
    push_idle(3);
    push_frame(8'h5A, 1'b0);
    bus_write(BASE, 32'h5A);
    wait_drain(100);
    check("post_rst_done", rd_data, 32'h0000_0020);

    mon_active = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/otter_uart_tx.md
Name: otter_uart_tx

Overview:
- Memory-mapped UART transmitter on the OTTER I/O bus, directly downstream of the MCU.
- Consumes the MCU's iobus_addr/iobus_out/iobus_wr, serialises bytes through a small FIFO onto a TX line, and returns status on a read-data bus that is muxed into iobus_in.
- Raises a one-cycle interrupt into the MCU intr input when the transmitter drains.

Parameters:
BASE_ADDR, 32'h1100_0200, byte address of TXDATA; STATUS/CTRL at BASE_ADDR+4
CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); legal range 2..65535
FIFO_DEPTH, 4, byte entries; power of two, 2..16

Ports:
clk  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
iobus_addr  in  32  MCU I/O address
iobus_out  in  32  MCU write data
iobus_wr  in  1  MCU I/O write strobe, one cycle
rd_data  out  32  read data for the iobus_in mux; zero when the address does not match
tx  out  1  serial line, idles high
intr  out  1  interrupt pulse to the MCU

Behaviour:
- Clock and reset: one clock, clk. RST is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - tx=1, intr=0, state=IDLE.
  - FIFO empty, count=0, pointers=0.
  - irq_en=0, overflow=0, baud counter=0, bit index=0.
- Reset asserted mid-frame aborts the frame; tx=1 from the next edge.
- Address decode: exact 32-bit compare against BASE_ADDR and BASE_ADDR+4. No other address has any effect.
- Write to TXDATA (iobus_wr=1, addr=BASE_ADDR):
  - If count<FIFO_DEPTH at the start of the cycle, push iobus_out[7:0].
  - Otherwise drop the byte and set overflow=1 (sticky).
  - A pop in the same cycle does not rescue a push to a full FIFO.
- Write to CTRL (iobus_wr=1, addr=BASE_ADDR+4):
  - irq_en <= iobus_out[0].
  - If iobus_out[1]=1, overflow <= 0.
- rd_data (combinational, valid the same cycle as iobus_addr):
  - addr=BASE_ADDR+4: {22'b0, overflow, irq_en, busy, full, empty, count[4:0]}, with count zero-extended to 5 bits.
  - busy = (state!=IDLE).
  - Every other address, including BASE_ADDR: 32'b0.
- FIFO: circular buffer. Read and write pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH. Simultaneous push (non-full) and pop leaves count unchanged.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if FIFO non-empty, pop the head into a shift register and go to START. tx=1 while in IDLE.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx = shift[0], held CLKS_PER_BIT cycles per bit, LSB first. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the final cycle:
    - FIFO non-empty: pop and go directly to START (no idle gap).
    - FIFO empty: go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and restarts on every state or bit change. A frame occupies exactly 10*CLKS_PER_BIT cycles on tx.
- Latency: a TXDATA write sampled at edge E0 with the FIFO empty and state IDLE causes IDLE to pop at edge E1. tx goes low at E1+1.
- intr:
  - Asserted for exactly one cycle, at the edge where STOP exits to IDLE, iff irq_en=1.
  - Never asserted by reset, by writes, or while irq_en=0.
  - Enabling irq_en while already idle does not fire intr.
- tx is registered and glitch-free.

Test Plan:
- Reset then idle: assert RST 2 cycles, CLKS_PER_BIT=4 -> tx=1, intr=0; rd_data at BASE+4 = 32'h0000_0020 (empty=1, count=0). rd_data at BASE+0 = 0.
- Single byte 8'hA5, CLKS_PER_BIT=4: write at E0 -> tx low from E2 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. busy=1 throughout. With irq_en=1, intr pulses one cycle at frame end.
- Back-to-back: write 8'h01, 8'h02, 8'h03 on consecutive cycles -> three contiguous 40-cycle frames with no idle cycles between them. count reads 2 one cycle after the third write. A single intr pulse after the third frame.
- Overflow: with FIFO_DEPTH=4, write 6 bytes in consecutive cycles while the first frame is in progress -> 5 frames transmitted, 6th byte dropped, status bit 9 = 1. Write CTRL 32'h3 -> overflow=0, irq_en=1.
- Reset mid-frame: assert RST during DATA bit 3 -> tx=1 next edge, FIFO empty, no intr. A fresh write afterwards transmits normally.
- Decode isolation: write BASE+8 and BASE-4 with 32'hFF, and read any non-matching address -> no push, no CTRL change, rd_data=0.
